// File: rtl/getir_pkg.sv
// -----------------------------------------------------------------------------
// getir_pkg -- shared constants for the instruction fetch unit.
//   * durum_e                : fetch FSM state encodings (ISTEK/BEKLE/IPTAL)
//   * PS_BIT_VARSAYILAN      : default program counter / address / word width
//   * RESET_PS_VARSAYILAN    : default program counter value after reset
//   * JAL_OPCODE             : RISC-V JAL major opcode (bits [6:0])
//   * j_imm()                : extracts the 21-bit J-type immediate (bit0 = 0)
// -----------------------------------------------------------------------------
package getir_pkg;

    typedef enum logic [1:0] {
        ISTEK = 2'd0,   // request phase: present address to memory
        BEKLE = 2'd1,   // waiting for the response of an accepted request
        IPTAL = 2'd2    // a flushed request is still in flight; drop its data
    } durum_e;

    localparam int          PS_BIT_VARSAYILAN   = 32;
    localparam logic [31:0] RESET_PS_VARSAYILAN = 32'h4000_0000;
    localparam logic [6:0]  JAL_OPCODE          = 7'b1101111;

    // J-type immediate: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
    function automatic logic [20:0] j_imm(input logic [31:0] buyruk);
        j_imm = {buyruk[31], buyruk[19:12], buyruk[20], buyruk[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/getir_tampon.sv
// -----------------------------------------------------------------------------
// getir_tampon -- one-entry hold buffer for a fetched instruction that could
// not enter the decode output register because decode is stalled.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   temizle_i            flush: empties the entry (highest priority)
//   yaz_i                load buyruk_i/ps_i/atladi_i into the entry
//   oku_i                the entry was consumed; empty it
//   buyruk_i, ps_i, atladi_i   data to store
//   gecerli_o            entry holds data
//   buyruk_o, ps_o, atladi_o   stored data (registered)
// -----------------------------------------------------------------------------
import getir_pkg::*;

module getir_tampon #(
    parameter int W = PS_BIT_VARSAYILAN
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         temizle_i,
    input  logic         yaz_i,
    input  logic         oku_i,
    input  logic [W-1:0] buyruk_i,
    input  logic [W-1:0] ps_i,
    input  logic         atladi_i,
    output logic         gecerli_o,
    output logic [W-1:0] buyruk_o,
    output logic [W-1:0] ps_o,
    output logic         atladi_o
);

    logic         r_gecerli;
    logic [W-1:0] r_buyruk;
    logic [W-1:0] r_ps;
    logic         r_atladi;

    // Entry storage: flush beats a write, a write (refill) beats a read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gecerli <= 1'b0;
            r_buyruk  <= '0;
            r_ps      <= '0;
            r_atladi  <= 1'b0;
        end else if (temizle_i) begin
            r_gecerli <= 1'b0;
        end else if (yaz_i) begin
            r_gecerli <= 1'b1;
            r_buyruk  <= buyruk_i;
            r_ps      <= ps_i;
            r_atladi  <= atladi_i;
        end else if (oku_i) begin
            r_gecerli <= 1'b0;
        end else begin
            r_gecerli <= r_gecerli;
        end
    end

    assign gecerli_o = r_gecerli;
    assign buyruk_o  = r_buyruk;
    assign ps_o      = r_ps;
    assign atladi_o  = r_atladi;

endmodule

// File: rtl/getir.sv
// -----------------------------------------------------------------------------
// getir -- instruction fetch unit with at most one outstanding memory request.
// Optional feature: define GETIR_JAL_ONGORU_EN to redirect fetch statically on
// JAL instructions (next pc = pc + J-immediate, getir_atladi_o = 1).
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   cek_bosalt_i, cek_ps_i        flush/redirect request and target
//   coz_duraklat_i                decode stall; decode outputs hold
//   bellek_istek_o, bellek_adres_o        memory request valid / address
//   bellek_istek_hazir_i                  memory accepts request this cycle
//   bellek_yanit_gecerli_i, bellek_yanit_veri_i   memory response
//   getir_buyruk_o, getir_ps_o, getir_gecerli_o, getir_atladi_o
//                                 registered outputs to decode
// -----------------------------------------------------------------------------
import getir_pkg::*;

module getir #(
    parameter int                PS_BIT   = PS_BIT_VARSAYILAN,
    parameter logic [PS_BIT-1:0] RESET_PS = PS_BIT'(RESET_PS_VARSAYILAN)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cek_bosalt_i,
    input  logic [PS_BIT-1:0] cek_ps_i,
    input  logic              coz_duraklat_i,
    output logic              bellek_istek_o,
    output logic [PS_BIT-1:0] bellek_adres_o,
    input  logic              bellek_istek_hazir_i,
    input  logic              bellek_yanit_gecerli_i,
    input  logic [PS_BIT-1:0] bellek_yanit_veri_i,
    output logic [PS_BIT-1:0] getir_buyruk_o,
    output logic [PS_BIT-1:0] getir_ps_o,
    output logic              getir_gecerli_o,
    output logic              getir_atladi_o
);

    durum_e            r_durum;
    durum_e            w_durum_sonraki;
    logic [PS_BIT-1:0] r_ps;
    logic [PS_BIT-1:0] w_ps_sonraki;
    logic              w_atladi_yeni;
    logic              w_istek;
    logic              w_kabul;
    logic              w_yakala;

    logic [PS_BIT-1:0] r_buyruk;
    logic [PS_BIT-1:0] r_cikis_ps;
    logic              r_gecerli;
    logic              r_atladi;

    logic              w_tampon_gecerli;
    logic [PS_BIT-1:0] w_tampon_buyruk;
    logic [PS_BIT-1:0] w_tampon_ps;
    logic              w_tampon_atladi;
    logic              w_tampon_yaz;
    logic              w_tampon_oku;

    // Requests stop while the hold buffer is occupied, so a response can
    // never arrive with both the output register and the buffer full.
    assign w_istek  = (r_durum == ISTEK) && !w_tampon_gecerli;
    assign w_kabul  = w_istek && bellek_istek_hazir_i;
    assign w_yakala = (r_durum == BEKLE) && bellek_yanit_gecerli_i && !cek_bosalt_i;

    assign bellek_istek_o = w_istek;
    assign bellek_adres_o = w_istek ? r_ps : '0;

    // Fetch FSM next state; flush handling folded into each state.
    always_comb begin
        w_durum_sonraki = r_durum;
        case (r_durum)
            ISTEK: begin
                if (cek_bosalt_i) begin
                    w_durum_sonraki = w_kabul ? IPTAL : ISTEK;
                end else if (w_kabul) begin
                    w_durum_sonraki = BEKLE;
                end else begin
                    w_durum_sonraki = ISTEK;
                end
            end
            BEKLE: begin
                // A response always closes the request, flushed or not.
                if (bellek_yanit_gecerli_i) begin
                    w_durum_sonraki = ISTEK;
                end else if (cek_bosalt_i) begin
                    w_durum_sonraki = IPTAL;
                end else begin
                    w_durum_sonraki = BEKLE;
                end
            end
            IPTAL: begin
                if (bellek_yanit_gecerli_i) begin
                    w_durum_sonraki = ISTEK;
                end else begin
                    w_durum_sonraki = IPTAL;
                end
            end
            default: w_durum_sonraki = ISTEK;
        endcase
    end

    // Next fetch address after a captured word: sequential or JAL target.
    always_comb begin
        w_ps_sonraki  = r_ps + PS_BIT'(4);
        w_atladi_yeni = 1'b0;
`ifdef GETIR_JAL_ONGORU_EN
        if (bellek_yanit_veri_i[6:0] == JAL_OPCODE) begin
            w_ps_sonraki  = r_ps + {{(PS_BIT-21){j_imm(bellek_yanit_veri_i[31:0])[20]}},
                                    j_imm(bellek_yanit_veri_i[31:0])};
            w_atladi_yeni = 1'b1;
        end else begin
            w_ps_sonraki  = r_ps + PS_BIT'(4);
            w_atladi_yeni = 1'b0;
        end
`endif
    end

    // State and program counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_durum <= ISTEK;
            r_ps    <= RESET_PS;
        end else begin
            r_durum <= w_durum_sonraki;
            if (cek_bosalt_i) begin
                r_ps <= cek_ps_i;
            end else if (w_yakala) begin
                r_ps <= w_ps_sonraki;
            end else begin
                r_ps <= r_ps;
            end
        end
    end

    // A captured word goes to the buffer when the output register is busy
    // (stalled with valid data) or is being refilled from the buffer.
    assign w_tampon_oku = !coz_duraklat_i && w_tampon_gecerli;
    assign w_tampon_yaz = w_yakala &&
                          ((coz_duraklat_i && r_gecerli) || w_tampon_oku);

    // Decode output register: buffered word first, then a new response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gecerli  <= 1'b0;
            r_buyruk   <= '0;
            r_cikis_ps <= '0;
            r_atladi   <= 1'b0;
        end else if (cek_bosalt_i) begin
            r_gecerli  <= 1'b0;
        end else if (!coz_duraklat_i) begin
            if (w_tampon_gecerli) begin
                r_gecerli  <= 1'b1;
                r_buyruk   <= w_tampon_buyruk;
                r_cikis_ps <= w_tampon_ps;
                r_atladi   <= w_tampon_atladi;
            end else if (w_yakala) begin
                r_gecerli  <= 1'b1;
                r_buyruk   <= bellek_yanit_veri_i;
                r_cikis_ps <= r_ps;
                r_atladi   <= w_atladi_yeni;
            end else begin
                r_gecerli  <= 1'b0;
            end
        end else if (w_yakala && !r_gecerli) begin
            // Stalled on a bubble: filling it does not disturb decode.
            r_gecerli  <= 1'b1;
            r_buyruk   <= bellek_yanit_veri_i;
            r_cikis_ps <= r_ps;
            r_atladi   <= w_atladi_yeni;
        end else begin
            r_gecerli  <= r_gecerli;
        end
    end

    getir_tampon #(.W(PS_BIT)) u_tampon (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .temizle_i (cek_bosalt_i),
        .yaz_i     (w_tampon_yaz),
        .oku_i     (w_tampon_oku),
        .buyruk_i  (bellek_yanit_veri_i),
        .ps_i      (r_ps),
        .atladi_i  (w_atladi_yeni),
        .gecerli_o (w_tampon_gecerli),
        .buyruk_o  (w_tampon_buyruk),
        .ps_o      (w_tampon_ps),
        .atladi_o  (w_tampon_atladi)
    );

    assign getir_buyruk_o  = r_buyruk;
    assign getir_ps_o      = r_cikis_ps;
    assign getir_gecerli_o = r_gecerli;
`ifdef GETIR_JAL_ONGORU_EN
    assign getir_atladi_o  = r_atladi;
`else
    assign getir_atladi_o  = 1'b0;
`endif

endmodule

// File: tb/tb_getir.sv
// -----------------------------------------------------------------------------
// tb_getir -- directed bench for getir. Inputs change 1 ns after a rising
// edge; outputs are sampled at the same point, well away from the next edge.
// Expected JAL behaviour follows GETIR_JAL_ONGORU_EN as seen by this file.
// -----------------------------------------------------------------------------
module tb_getir;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cek_bosalt_i;
    logic [31:0] cek_ps_i;
    logic        coz_duraklat_i;
    logic        bellek_istek_o;
    logic [31:0] bellek_adres_o;
    logic        bellek_istek_hazir_i;
    logic        bellek_yanit_gecerli_i;
    logic [31:0] bellek_yanit_veri_i;
    logic [31:0] getir_buyruk_o;
    logic [31:0] getir_ps_o;
    logic        getir_gecerli_o;
    logic        getir_atladi_o;

    int n_kontrol = 0;
    int n_hata    = 0;

    getir dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .cek_bosalt_i           (cek_bosalt_i),
        .cek_ps_i               (cek_ps_i),
        .coz_duraklat_i         (coz_duraklat_i),
        .bellek_istek_o         (bellek_istek_o),
        .bellek_adres_o         (bellek_adres_o),
        .bellek_istek_hazir_i   (bellek_istek_hazir_i),
        .bellek_yanit_gecerli_i (bellek_yanit_gecerli_i),
        .bellek_yanit_veri_i    (bellek_yanit_veri_i),
        .getir_buyruk_o         (getir_buyruk_o),
        .getir_ps_o             (getir_ps_o),
        .getir_gecerli_o        (getir_gecerli_o),
        .getir_atladi_o         (getir_atladi_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        n_kontrol++;
        if (gozlenen !== beklenen) begin
            n_hata++;
            $display("FAIL %s: got %h expected %h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic tik();
        @(posedge clk_i);
        #1;
    endtask

    // Memory accepts the pending request on this edge.
    task automatic kabul();
        bellek_istek_hazir_i = 1'b1;
        tik();
        bellek_istek_hazir_i = 1'b0;
    endtask

    // Memory returns a word on this edge.
    task automatic yanit(input logic [31:0] veri);
        bellek_yanit_gecerli_i = 1'b1;
        bellek_yanit_veri_i    = veri;
        tik();
        bellek_yanit_gecerli_i = 1'b0;
    endtask

    // Redirect on this edge.
    task automatic bosalt(input logic [31:0] hedef);
        cek_bosalt_i = 1'b1;
        cek_ps_i     = hedef;
        tik();
        cek_bosalt_i = 1'b0;
    endtask

    initial begin
        rst_i                  = 1'b1;
        cek_bosalt_i           = 1'b0;
        cek_ps_i               = 32'h0;
        coz_duraklat_i         = 1'b0;
        bellek_istek_hazir_i   = 1'b0;
        bellek_yanit_gecerli_i = 1'b0;
        bellek_yanit_veri_i    = 32'h0;
        tik();
        tik();
        rst_i = 1'b0;

        // Reset state
        kontrol("rst_gecerli", 32'(getir_gecerli_o), 32'd0);
        kontrol("rst_buyruk",  getir_buyruk_o,       32'h0);
        kontrol("rst_ps",      getir_ps_o,           32'h0);
        kontrol("rst_atladi",  32'(getir_atladi_o),  32'd0);
        kontrol("rst_istek",   32'(bellek_istek_o),  32'd1);
        kontrol("rst_adres",   bellek_adres_o,       32'h4000_0000);

        // First fetch: accept, response next cycle, output one cycle later
        kabul();
        kontrol("bekle_istek", 32'(bellek_istek_o), 32'd0);
        yanit(32'h0000_0013);
        kontrol("f1_gecerli", 32'(getir_gecerli_o), 32'd1);
        kontrol("f1_buyruk",  getir_buyruk_o,       32'h0000_0013);
        kontrol("f1_ps",      getir_ps_o,           32'h4000_0000);
        kontrol("f1_adres2",  bellek_adres_o,       32'h4000_0004);

        // Stall: new word is held, outputs frozen, no further request
        coz_duraklat_i = 1'b1;
        kabul();
        yanit(32'h00A0_0093);
        kontrol("st_buyruk",  getir_buyruk_o,       32'h0000_0013);
        kontrol("st_ps",      getir_ps_o,           32'h4000_0000);
        kontrol("st_gecerli", 32'(getir_gecerli_o), 32'd1);
        kontrol("st_istek",   32'(bellek_istek_o),  32'd0);
        tik();
        kontrol("st2_buyruk", getir_buyruk_o,       32'h0000_0013);
        coz_duraklat_i = 1'b0;
        tik();
        kontrol("rl_buyruk",  getir_buyruk_o,       32'h00A0_0093);
        kontrol("rl_ps",      getir_ps_o,           32'h4000_0004);
        kontrol("rl_gecerli", 32'(getir_gecerli_o), 32'd1);
        kontrol("rl_adres",   bellek_adres_o,       32'h4000_0008);
        tik();
        kontrol("bos_gecerli", 32'(getir_gecerli_o), 32'd0);

        // Flush while waiting: stale response discarded
        kabul();
        bosalt(32'h8000_0000);
        kontrol("ip_istek",   32'(bellek_istek_o),  32'd0);
        kontrol("ip_gecerli", 32'(getir_gecerli_o), 32'd0);
        yanit(32'hDEAD_BEEF);
        kontrol("ip2_gecerli", 32'(getir_gecerli_o), 32'd0);
        kontrol("ip2_istek",   32'(bellek_istek_o),  32'd1);
        kontrol("ip2_adres",   bellek_adres_o,       32'h8000_0000);

        // Flush coinciding with the response
        kabul();
        bellek_yanit_gecerli_i = 1'b1;
        bellek_yanit_veri_i    = 32'h1111_1111;
        bosalt(32'h9000_0000);
        bellek_yanit_gecerli_i = 1'b0;
        kontrol("fr_istek",   32'(bellek_istek_o),  32'd1);
        kontrol("fr_adres",   bellek_adres_o,       32'h9000_0000);
        kontrol("fr_gecerli", 32'(getir_gecerli_o), 32'd0);

        // JAL +16 at 0x4000_0000
        bosalt(32'h4000_0000);
        kontrol("j_adres0", bellek_adres_o, 32'h4000_0000);
        kabul();
        yanit(32'h0100_006F);
        kontrol("j_buyruk", getir_buyruk_o, 32'h0100_006F);
        kontrol("j_ps",     getir_ps_o,     32'h4000_0000);
`ifdef GETIR_JAL_ONGORU_EN
        kontrol("j_adres",  bellek_adres_o,      32'h4000_0010);
        kontrol("j_atladi", 32'(getir_atladi_o), 32'd1);
`else
        kontrol("j_adres",  bellek_adres_o,      32'h4000_0004);
        kontrol("j_atladi", 32'(getir_atladi_o), 32'd0);
`endif

        // Address wrap at the top of the space
        bosalt(32'hFFFF_FFFC);
        kabul();
        yanit(32'h0000_0013);
        kontrol("w_adres", bellek_adres_o, 32'h0000_0000);
        kontrol("w_ps",    getir_ps_o,     32'hFFFF_FFFC);
        kontrol("w_atladi", 32'(getir_atladi_o), 32'd0);

        // Flush while stalled with a word in the hold buffer clears both
        coz_duraklat_i = 1'b1;
        kabul();
        yanit(32'h2222_2222);
        kontrol("hb_istek", 32'(bellek_istek_o), 32'd0);
        bosalt(32'h5000_0000);
        kontrol("hb_gecerli", 32'(getir_gecerli_o), 32'd0);
        kontrol("hb_istek2",  32'(bellek_istek_o),  32'd1);
        kontrol("hb_adres",   bellek_adres_o,       32'h5000_0000);
        coz_duraklat_i = 1'b0;
        tik();
        kontrol("hb_gecerli2", 32'(getir_gecerli_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_kontrol, n_hata);
        $finish;
    end

endmodule
